div_seq_ctl: RTL and testbench

//  Sequences the EX-stage iterative divider of the 5-stage MIPS pipeline.

---
 rtl/div_seq_ctl_pkg.sv | 14 +
 rtl/div_seq_ctl_iter_counter.sv | 39 +++
 rtl/div_seq_ctl.sv | 116 +++++++++++
 tb/tb_div_seq_ctl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_ctl_pkg.sv
// Shared definitions for the EX-stage divider sequencer: state encoding and the
// default iteration count that the ALU divider is built around.
package div_seq_ctl_pkg;

    localparam int DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_ctl_iter_counter.sv
// Iteration up-counter for the divider sequencer: sync clear, count enable and
// a terminal flag raised when the count equals LAST.
module iter_counter #(
    parameter int CNT_W = 6,
    parameter int LAST  = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST_V);

endmodule

// File: rtl/div_seq_ctl.sv
// Sequencer for the iterative DIVU unit in EX: pulses the divider reset, runs the
// iterations, stalls the front of the pipe and writes HI/LO when the result is ready.
module div_seq_ctl
    import div_seq_ctl_pkg::*;
#(
    parameter int W          = 32,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req,
    input  logic [W-1:0]     divisor,
    input  logic             flush,
    output logic             div_reset,
    output logic             div_run,
    output logic             stall,
    output logic             hilo_we,
    output logic             dbz,
    output logic             busy,
    output logic [CNT_W-1:0] iter
);

    div_state_e       state_q, state_d;
    logic             dbz_q, dbz_d;
    logic             cnt_clr, cnt_en, cnt_last;
    logic [CNT_W-1:0] cnt;

    iter_counter #(
        .CNT_W (CNT_W),
        .LAST  (DIV_CYCLES - 1)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        dbz_d     = dbz_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        div_reset = 1'b0;
        div_run   = 1'b0;
        stall     = 1'b0;
        hilo_we   = 1'b0;
        dbz       = 1'b0;
        busy      = 1'b0;
        iter      = '0;
        if (rst) begin
            state_d = ST_IDLE;
            dbz_d   = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            busy = (state_q != ST_IDLE);
            iter = cnt;
            case (state_q)
                ST_IDLE: begin
                    // A request killed by a flush this cycle never starts.
                    if (div_req && !flush) begin
                        stall = 1'b1;
                        if (divisor != '0) begin
                            state_d = ST_INIT;
                        end else begin
                            state_d = ST_DONE;
                            dbz_d   = 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    div_reset = 1'b1;
                    stall     = !flush;
                    cnt_clr   = 1'b1;
                    state_d   = flush ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    div_run = 1'b1;
                    stall   = !flush;
                    if (flush) begin
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end else if (cnt_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_DONE: begin
                    hilo_we = !flush;
                    dbz     = dbz_q;
                    dbz_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    // The DIVU must stay present in EX for the whole iteration unless it is flushed.
    a_req_held_in_run: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_RUN && !flush) |-> div_req);

endmodule

// File: tb/tb_div_seq_ctl.sv
// Directed bench for div_seq_ctl: a cycle-level latency model checked every cycle,
// plus literal expectations on pulse timing and stall counts per scenario.
module tb_div_seq_ctl;

    localparam int W     = 32;
    localparam int D     = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst, div_req, flush;
    logic [W-1:0]     divisor;
    logic             div_reset, div_run, stall, hilo_we, dbz, busy;
    logic [CNT_W-1:0] iter;

    div_seq_ctl #(.W(W), .DIV_CYCLES(D), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_req   (div_req),
        .divisor   (divisor),
        .flush     (flush),
        .div_reset (div_reset),
        .div_run   (div_run),
        .stall     (stall),
        .hilo_we   (hilo_we),
        .dbz       (dbz),
        .busy      (busy),
        .iter      (iter)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted divide is tracked by its age in cycles since acceptance.
    // Nonzero divisor: age 1 reset pulse, ages 2..D+1 iterate, age D+2 writeback.
    // Zero divisor: writeback at age 1.
    bit m_active = 1'b0;
    bit m_zero   = 1'b0;
    int m_age    = 0;
    int m_iter   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_iter   <= 0;
        end else if (!m_active) begin
            if (div_req && !flush) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_zero   <= (divisor == '0);
            end
        end else if (m_zero || m_age == D + 2) begin
            m_active <= 1'b0;
        end else if (flush) begin
            m_active <= 1'b0;
            m_iter   <= 0;
        end else begin
            m_age  <= m_age + 1;
            m_iter <= (m_age == 1) ? 0 : ((m_age - 1 > D - 1) ? D - 1 : m_age - 1);
        end
    end

    // Per-scenario recorders.
    int stall_cnt, run_cnt, last_dbz;
    int rst_q[$];
    int we_q[$];

    always @(negedge clk) begin
        int e_rst, e_run, e_stall, e_we, e_dbz, e_busy, e_iter;
        e_rst = 0; e_run = 0; e_stall = 0; e_we = 0; e_dbz = 0; e_busy = 0;
        e_iter = m_iter;
        if (rst) begin
            e_iter = 0;
        end else if (!m_active) begin
            e_stall = int'(div_req && !flush);
        end else begin
            e_busy = 1;
            if (m_zero || m_age == D + 2) begin
                e_we  = int'(!flush);
                e_dbz = int'(m_zero);
            end else if (m_age == 1) begin
                e_rst   = 1;
                e_stall = int'(!flush);
            end else begin
                e_run   = 1;
                e_stall = int'(!flush);
                e_iter  = m_age - 2;
            end
        end
        check("div_reset", int'(div_reset), e_rst);
        check("div_run",   int'(div_run),   e_run);
        check("stall",     int'(stall),     e_stall);
        check("hilo_we",   int'(hilo_we),   e_we);
        check("dbz",       int'(dbz),       e_dbz);
        check("busy",      int'(busy),      e_busy);
        check("iter",      int'(iter),      e_iter);

        stall_cnt += int'(stall);
        run_cnt   += int'(div_run);
        if (div_reset) rst_q.push_back(cyc);
        if (hilo_we) begin
            we_q.push_back(cyc);
            last_dbz = int'(dbz);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        stall_cnt = 0;
        run_cnt   = 0;
        last_dbz  = 0;
        rst_q.delete();
        we_q.delete();
    endtask

    // Present a DIVU for 'hold' cycles starting now; flush on offset flush_at.
    task automatic issue(input logic [W-1:0] dv, input int hold, input int flush_at);
        div_req = 1'b1;
        divisor = dv;
        for (int i = 0; i < hold; i++) begin
            flush = (i == flush_at);
            step();
        end
        div_req = 1'b0;
        flush   = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (q.size() > idx) ? q[idx] : -1;
    endfunction

    initial begin
        int t;
        rst = 1'b1; div_req = 1'b1; divisor = 32'd7; flush = 1'b0;
        clear_rec();
        step();
        step();

        // Reset release with a DIVU already waiting, then the normal 34-cycle stall.
        rst = 1'b0;
        t = cyc;
        @(negedge clk);
        check("post_reset_stall", int'(stall), 1);
        repeat (35) step();
        div_req = 1'b0;
        step();
        check("norm_reset_cnt", rst_q.size(), 1);
        check("norm_reset_cyc", q_at(rst_q, 0), t + 1);
        check("norm_run_cnt", run_cnt, 32);
        check("norm_we_cyc", q_at(we_q, 0), t + 34);
        check("norm_dbz", last_dbz, 0);
        check("norm_stall_cnt", stall_cnt, 34);
        $display("normal divisor=7: stall=%0d run=%0d we@+%0d", stall_cnt, run_cnt, q_at(we_q, 0) - t);

        // Divide by zero.
        clear_rec();
        t = cyc;
        issue(32'd0, 2, -1);
        step();
        check("dbz_stall_cnt", stall_cnt, 1);
        check("dbz_reset_cnt", rst_q.size(), 0);
        check("dbz_run_cnt", run_cnt, 0);
        check("dbz_we_cyc", q_at(we_q, 0), t + 1);
        check("dbz_flag", last_dbz, 1);
        $display("div by zero: stall=%0d we@+%0d dbz=%0d", stall_cnt, q_at(we_q, 0) - t, last_dbz);

        // Flush in the middle of the iteration.
        clear_rec();
        t = cyc;
        issue(32'd9, 11, 10);
        @(negedge clk);
        check("flush_run_busy", int'(busy), 0);
        check("flush_run_iter", int'(iter), 0);
        step();
        check("flush_run_stall", stall_cnt, 10);
        check("flush_run_we", we_q.size(), 0);
        check("flush_run_runs", run_cnt, 9);
        $display("flush mid-run: stall=%0d run=%0d we=%0d", stall_cnt, run_cnt, we_q.size());

        // Flush arriving in the writeback cycle.
        clear_rec();
        issue(32'd7, 35, 34);
        @(negedge clk);
        check("flush_done_busy", int'(busy), 0);
        step();
        check("flush_done_we", we_q.size(), 0);
        check("flush_done_stall", stall_cnt, 34);
        $display("flush in done: stall=%0d we=%0d", stall_cnt, we_q.size());

        // Request and flush together: never accepted.
        clear_rec();
        issue(32'd7, 1, 0);
        step();
        check("flush_req_stall", stall_cnt, 0);
        check("flush_req_reset", rst_q.size(), 0);
        $display("flush with request: stall=%0d", stall_cnt);

        // Back-to-back DIVU.
        clear_rec();
        t = cyc;
        issue(32'd3, 35, -1);
        issue(32'd5, 35, -1);
        step();
        step();
        check("b2b_stall_cnt", stall_cnt, 68);
        check("b2b_reset_cnt", rst_q.size(), 2);
        check("b2b_we_cnt", we_q.size(), 2);
        check("b2b_gap", q_at(rst_q, 1) - q_at(we_q, 0), 2);
        check("b2b_we2_cyc", q_at(we_q, 1), t + 69);
        $display("back-to-back: stall=%0d gap=%0d", stall_cnt, q_at(rst_q, 1) - q_at(we_q, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
